// File: rtl/slice_sequencer.sv
// rtl/slice_sequencer.sv - slicer job sequencer: ranging, piece length division, move/cut loop with pause
// Drives one ranging request, divides the object into equal pieces, then alternates mover and cutter strokes.
module slice_sequencer #(
  parameter int STEPS_PER_CM  = 10,
  parameter int MAX_SLICE     = 20,
  parameter int RANGE_TIMEOUT = 3_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        slice_i,
  output logic        range_req_o,
  input  logic        range_valid_i,
  input  logic [8:0]  range_cm_i,
  output logic        move_req_o,
  output logic [15:0] move_steps_o,
  input  logic        move_done_i,
  output logic        cut_req_o,
  input  logic        cut_done_i,
  output logic        hold_o,
  output logic [4:0]  slice_num_o,
  output logic        finish_o,
  output logic        error_o,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RANGE  = 4'd1,
    S_CALC   = 4'd2,
    S_MOVE   = 4'd3,
    S_CUT    = 4'd4,
    S_NEXT   = 4'd5,
    S_DONE   = 4'd6,
    S_PAUSED = 4'd7
  } state_t;

  localparam logic [4:0]  SLICE_MAX = 5'(MAX_SLICE);
  localparam logic [31:0] TMO_LAST  = 32'(RANGE_TIMEOUT - 1);
  localparam logic [31:0] SPC       = 32'(STEPS_PER_CM);

  state_t      state_q, state_d;
  state_t      saved_q, saved_d;
  logic [31:0] tmo_q, tmo_d;
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  piece_q, piece_d;
  logic [4:0]  cut_cnt_q, cut_cnt_d;
  logic [4:0]  slice_q, slice_d;
  logic        done_lat_q, done_lat_d;
  logic        pause_pend_q, pause_pend_d;
  logic        range_req_d, move_req_d, cut_req_d, finish_d, hold_d, error_d;
  logic [15:0] steps_d;
  logic [47:0] product;
  logic        move_done, cut_done;

  assign product   = {39'd0, piece_q} * {16'd0, SPC};
  // A done pulse captured while paused counts as arriving once the saved state resumes.
  assign move_done = move_done_i | done_lat_q;
  assign cut_done  = cut_done_i | done_lat_q;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    tmo_d        = tmo_q;
    rem_d        = rem_q;
    piece_d      = piece_q;
    cut_cnt_d    = cut_cnt_q;
    slice_d      = slice_q;
    done_lat_d   = done_lat_q;
    pause_pend_d = pause_pend_q;
    range_req_d  = 1'b0;
    move_req_d   = 1'b0;
    cut_req_d    = 1'b0;
    finish_d     = 1'b0;
    hold_d       = hold_o;
    error_d      = error_o;
    steps_d      = move_steps_o;

    case (state_q)
      S_IDLE: begin
        tmo_d        = '0;
        done_lat_d   = 1'b0;
        pause_pend_d = 1'b0;
        if (slice_i) begin
          slice_d = (slice_q >= SLICE_MAX) ? 5'd1 : slice_q + 5'd1;
        end
        if (start_i) begin
          error_d     = 1'b0;
          range_req_d = 1'b1;
          cut_cnt_d   = '0;
          state_d     = S_RANGE;
        end
      end
      S_RANGE: begin
        if (range_valid_i) begin
          rem_d   = range_cm_i;
          piece_d = '0;
          state_d = S_CALC;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_CALC: begin
        // Zero pieces covers both range == 0 and range < slice count.
        if (rem_q >= {4'd0, slice_q}) begin
          rem_d   = rem_q - {4'd0, slice_q};
          piece_d = piece_q + 9'd1;
        end else if (piece_q == '0) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          steps_d = (product > 48'hFFFF) ? 16'hFFFF : product[15:0];
          if (slice_q == 5'd1) begin
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            move_req_d = 1'b1;
            state_d    = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (move_done) begin
          done_lat_d   = 1'b0;
          cut_req_d    = 1'b1;
          pause_pend_d = pause_i;
          state_d      = S_CUT;
        end else if (pause_i) begin
          saved_d = S_MOVE;
          hold_d  = 1'b1;
          state_d = S_PAUSED;
        end
      end
      S_CUT: begin
        if (cut_done) begin
          done_lat_d   = 1'b0;
          pause_pend_d = 1'b0;
          state_d      = S_NEXT;
        end else if (pause_i || pause_pend_q) begin
          pause_pend_d = 1'b0;
          saved_d      = S_CUT;
          hold_d       = 1'b1;
          state_d      = S_PAUSED;
        end
      end
      S_NEXT: begin
        cut_cnt_d = cut_cnt_q + 5'd1;
        if ((cut_cnt_q + 5'd1) == (slice_q - 5'd1)) begin
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          move_req_d = 1'b1;
          state_d    = S_MOVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_PAUSED: begin
        if ((saved_q == S_MOVE && move_done_i) || (saved_q == S_CUT && cut_done_i)) begin
          done_lat_d = 1'b1;
        end
        if (pause_i) begin
          hold_d  = 1'b0;
          state_d = saved_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      saved_q      <= S_IDLE;
      tmo_q        <= '0;
      rem_q        <= '0;
      piece_q      <= '0;
      cut_cnt_q    <= '0;
      slice_q      <= 5'd1;
      done_lat_q   <= 1'b0;
      pause_pend_q <= 1'b0;
      range_req_o  <= 1'b0;
      move_req_o   <= 1'b0;
      cut_req_o    <= 1'b0;
      finish_o     <= 1'b0;
      hold_o       <= 1'b0;
      error_o      <= 1'b0;
      move_steps_o <= '0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      tmo_q        <= tmo_d;
      rem_q        <= rem_d;
      piece_q      <= piece_d;
      cut_cnt_q    <= cut_cnt_d;
      slice_q      <= slice_d;
      done_lat_q   <= done_lat_d;
      pause_pend_q <= pause_pend_d;
      range_req_o  <= range_req_d;
      move_req_o   <= move_req_d;
      cut_req_o    <= cut_req_d;
      finish_o     <= finish_d;
      hold_o       <= hold_d;
      error_o      <= error_d;
      move_steps_o <= steps_d;
    end
  end

  assign state_o     = state_q;
  assign slice_num_o = slice_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// tb/tb_slice_sequencer.sv - self-checking bench for slice_sequencer
// Job-level model: pieces, pair counts and error outcome from plain arithmetic; per-cycle pulse/hold/slice checks.
module tb_slice_sequencer;

  localparam int SPC  = 10;
  localparam int MAXS = 20;
  localparam int TMO  = 200;
  localparam int EV_M = 0, EV_C = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i = 1'b0, pause_i = 1'b0, slice_i = 1'b0;
  logic        range_valid_i = 1'b0;
  logic [8:0]  range_cm_i = '0;
  logic        move_done_i, cut_done_i;
  logic        range_req_o, move_req_o, cut_req_o, hold_o, finish_o, error_o;
  logic [15:0] move_steps_o;
  logic [4:0]  slice_num_o;
  logic [3:0]  state_o;

  logic resp_m = 1'b0, resp_c = 1'b0, man_m = 1'b0, man_c = 1'b0;
  assign move_done_i = resp_m | man_m;
  assign cut_done_i  = resp_c | man_c;

  always #10 clk = ~clk;

  slice_sequencer #(.STEPS_PER_CM(SPC), .MAX_SLICE(MAXS), .RANGE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pause_i(pause_i), .slice_i(slice_i),
    .range_req_o(range_req_o), .range_valid_i(range_valid_i), .range_cm_i(range_cm_i),
    .move_req_o(move_req_o), .move_steps_o(move_steps_o), .move_done_i(move_done_i),
    .cut_req_o(cut_req_o), .cut_done_i(cut_done_i), .hold_o(hold_o),
    .slice_num_o(slice_num_o), .finish_o(finish_o), .error_o(error_o), .state_o(state_o)
  );

  int checks = 0, errors = 0;
  int exp_slice = 1, exp_steps = 0;
  bit exp_hold = 0, job_active = 0, auto_resp = 1;
  int n_rreq = 0, n_mreq = 0, n_creq = 0, n_fin = 0;
  int base_m, base_c, base_f, job_pairs;
  bit job_err;
  bit prev_m = 0, prev_c = 0, prev_f = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_err(input int r, input int s);
    return (r == 0) || (r < s);
  endfunction
  function automatic int model_pairs(input int r, input int s);
    return model_err(r, s) ? 0 : s - 1;
  endfunction
  function automatic int model_steps(input int r, input int s);
    int p;
    p = (r / s) * SPC;
    return (p > 65535) ? 65535 : p;
  endfunction
  function automatic int cnt_of(input int which);
    return (which == EV_M) ? n_mreq : n_creq;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (range_req_o) n_rreq++;
      if (move_req_o) begin
        n_mreq++;
        check("mreq_width", 32'(prev_m), 0);
        if (job_active) check("steps_on_move", 32'(move_steps_o), exp_steps);
      end
      if (cut_req_o) begin
        n_creq++;
        check("creq_width", 32'(prev_c), 0);
      end
      if (finish_o) begin
        n_fin++;
        check("finish_width", 32'(prev_f), 0);
      end
      check("slice_num", 32'(slice_num_o), exp_slice);
      check("hold", 32'(hold_o), 32'(exp_hold));
      prev_m = move_req_o; prev_c = cut_req_o; prev_f = finish_o;
    end
  end

  // Motor drivers that answer each request after a short delay.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_resp && move_req_o) begin
        repeat (2) @(posedge clk);
        #1 resp_m = 1'b1;
        @(posedge clk);
        #1 resp_m = 1'b0;
      end else if (auto_resp && cut_req_o) begin
        repeat (3) @(posedge clk);
        #1 resp_c = 1'b1;
        @(posedge clk);
        #1 resp_c = 1'b0;
      end
    end
  end

  task automatic pulse_pause();
    @(posedge clk); #1 pause_i = 1'b1;
    @(posedge clk); #1 pause_i = 1'b0;
  endtask
  task automatic pulse_mdone();
    @(posedge clk); #1 man_m = 1'b1;
    @(posedge clk); #1 man_m = 1'b0;
  endtask
  task automatic pulse_cdone();
    @(posedge clk); #1 man_c = 1'b1;
    @(posedge clk); #1 man_c = 1'b0;
  endtask

  task automatic slice_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 slice_i = 1'b1;
      @(posedge clk); #1 slice_i = 1'b0;
      exp_slice = exp_slice % MAXS + 1;
    end
  endtask

  task automatic wait_evt(input int which, input int target);
    int k;
    k = 0;
    while (k < 1000 && cnt_of(which) < target) begin
      @(negedge clk); #1;
      k++;
    end
    check(which == EV_M ? "wait_move_req" : "wait_cut_req", 32'(cnt_of(which) >= target), 1);
  endtask

  task automatic begin_job(input int range, input bit reply);
    job_err   = model_err(range, exp_slice);
    job_pairs = model_pairs(range, exp_slice);
    exp_steps = model_steps(range, exp_slice);
    job_active = !job_err;
    base_m = n_mreq; base_c = n_creq; base_f = n_fin;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("error_cleared_by_start", 32'(error_o), 0);
    check("range_req_pulse", 32'(range_req_o), 1);
    check("state_range", 32'(state_o), 1);
    if (reply) begin
      @(posedge clk); #1 slice_i = 1'b1; start_i = 1'b1;
      @(posedge clk); #1 slice_i = 1'b0; start_i = 1'b0;
      range_valid_i = 1'b1; range_cm_i = 9'(range);
      @(posedge clk); #1 range_valid_i = 1'b0;
    end
  endtask

  task automatic end_job(input bit reply);
    int k, rcyc;
    k = 0; rcyc = 0;
    while (k < 3000) begin
      @(negedge clk); #1;
      if (state_o == 4'd1) rcyc++;
      if (state_o == 4'd0) break;
      k++;
    end
    check("job_returns_idle", 32'(state_o), 0);
    if (!reply) begin
      check("timeout_range_cycles", rcyc, TMO);
      check("timeout_error", 32'(error_o), 1);
      check("timeout_no_finish", n_fin - base_f, 0);
    end else begin
      check("job_error", 32'(error_o), 32'(job_err));
      check("move_pairs", n_mreq - base_m, job_pairs);
      check("cut_pairs", n_creq - base_c, job_pairs);
      check("finish_count", n_fin - base_f, job_err ? 0 : 1);
      if (!job_err) check("move_steps", 32'(move_steps_o), exp_steps);
    end
    job_active = 0;
  endtask

  task automatic run_job(input int range);
    begin_job(range, 1'b1);
    end_job(1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    #30;
    check("rst_state", 32'(state_o), 0);
    check("rst_slice", 32'(slice_num_o), 1);
    check("rst_steps", 32'(move_steps_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_hold", 32'(hold_o), 0);
    check("rst_pulses", 32'({range_req_o, move_req_o, cut_req_o, finish_o}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Wrap after a full lap of slice pulses; single slice means no motor work.
    slice_n(20);
    check("slice_wrap_lit", 32'(slice_num_o), 1);
    run_job(25);
    check("single_slice_steps_lit", 32'(move_steps_o), 250);

    slice_n(3);
    check("slice_four_lit", 32'(slice_num_o), 4);
    run_job(40);
    check("steps_100_lit", 32'(move_steps_o), 100);
    check("three_moves_lit", n_mreq - base_m, 3);

    slice_n(1);
    run_job(3);
    check("short_error_lit", 32'(error_o), 1);
    run_job(0);
    run_job(5);
    slice_n(16);
    run_job(511);

    begin_job(30, 1'b0);
    end_job(1'b0);
    run_job(7);

    // Pause around a move, done latched while paused, then done+pause together.
    slice_n(3);
    auto_resp = 0;
    begin_job(40, 1'b1);
    wait_evt(EV_M, base_m + 1);
    pulse_pause();
    exp_hold = 1;
    check("paused_state", 32'(state_o), 7);
    repeat (3) @(posedge clk);
    pulse_mdone();
    repeat (2) @(posedge clk);
    #1;
    check("still_paused", 32'(state_o), 7);
    check("no_cut_while_paused", n_creq - base_c, 0);
    pulse_pause();
    exp_hold = 0;
    wait_evt(EV_C, base_c + 1);
    check("move_not_reissued", n_mreq - base_m, 1);
    pulse_cdone();
    wait_evt(EV_M, base_m + 2);
    @(posedge clk); #1 pause_i = 1'b1; man_m = 1'b1;
    @(posedge clk); #1 pause_i = 1'b0; man_m = 1'b0;
    check("done_wins_state", 32'(state_o), 4);
    check("done_wins_cut_req", 32'(cut_req_o), 1);
    @(posedge clk); #1 exp_hold = 1;
    check("pause_after_done", 32'(state_o), 7);
    repeat (2) @(posedge clk);
    pulse_pause();
    exp_hold = 0;
    check("resume_cut", 32'(state_o), 4);
    check("cut_not_reissued", 32'(cut_req_o), 0);
    pulse_cdone();
    auto_resp = 1;
    end_job(1'b1);

    // Asynchronous reset while cutting.
    auto_resp = 0;
    begin_job(40, 1'b1);
    wait_evt(EV_M, base_m + 1);
    pulse_mdone();
    wait_evt(EV_C, base_c + 1);
    rst_n = 1'b0;
    #1;
    exp_slice = 1; exp_hold = 0; job_active = 0;
    check("arst_state", 32'(state_o), 0);
    check("arst_outputs", 32'({range_req_o, move_req_o, cut_req_o, finish_o, hold_o, error_o}), 0);
    check("arst_steps", 32'(move_steps_o), 0);
    check("arst_slice", 32'(slice_num_o), 1);
    base_m = n_mreq; base_c = n_creq; base_f = n_fin;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_finish", n_fin - base_f, 0);
    check("arst_no_requests", (n_mreq - base_m) + (n_creq - base_c), 0);
    check("arst_idle", 32'(state_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
